// File: rtl/xosera_pkg.sv
// Shared sprite geometry, FSM state encoding and nibble select helper for the
// sprite scanline fetch path.
package xosera_pkg;

  localparam int SPRITE_ROWS = 32;
  localparam int SPRITE_WPR  = 8;
  localparam int SPRITE_PIX  = 32;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, READY, SHIFT} spr_state_t;

  // sel 0 is the leftmost pixel of a word (bits 15:12)
  function automatic logic [3:0] nib_of(input logic [15:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    nib_of = w[15:12];
      2'd1:    nib_of = w[11:8];
      2'd2:    nib_of = w[7:4];
      default: nib_of = w[3:0];
    endcase
  endfunction

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// Sprite BRAM read port plus pixel output bundle between the fetch controller
// (master) and its BRAM / colour-stage neighbours (slave).
interface sprite_fetch_ctrl_if;

  logic        spr_rd_en_o;
  logic [7:0]  spr_rd_addr_o;
  logic [15:0] spr_rd_data_i;
  logic [3:0]  pixel_o;
  logic        pixel_valid_o;
  logic        busy_o;

  modport master (
    output spr_rd_en_o, spr_rd_addr_o, pixel_o, pixel_valid_o, busy_o,
    input  spr_rd_data_i
  );

  modport slave (
    input  spr_rd_en_o, spr_rd_addr_o, pixel_o, pixel_valid_o, busy_o,
    output spr_rd_data_i
  );

endinterface

// File: rtl/sprite_linebuf.sv
// 8x16 sprite row buffer with nibble read by pixel index.
// SPRITE_HFLIP_EN adds the horizontal flip select on the read side.
module sprite_linebuf
  import xosera_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic [4:0]  rd_idx,
`ifdef SPRITE_HFLIP_EN
  input  logic        hflip,
`endif
  output logic [3:0]  rd_nib
);

  logic [15:0] row_buf [SPRITE_WPR];
  logic [4:0]  eff_idx;

`ifdef SPRITE_HFLIP_EN
  // mirrored index 31-i walks word7[3:0] first
  assign eff_idx = hflip ? ~rd_idx : rd_idx;
`else
  assign eff_idx = rd_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SPRITE_WPR; i++) row_buf[i] <= '0;
    end else if (wr_en) begin
      row_buf[wr_idx] <= wr_data;
    end
  end

  assign rd_nib = nib_of(row_buf[eff_idx[4:2]], eff_idx[1:0]);

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Scanline sprite fetch sequencer: row hit test, 8-word BRAM fetch, 32-pixel
// serializer. Build option SPRITE_HFLIP_EN adds hflip_i.
//
// state   | meaning
// IDLE    | no sprite on this line / line finished
// FETCH   | issuing BRAM reads for words 0..7
// CAPTURE | last read word landing in the row buffer
// READY   | buffer full, waiting for h_count == sprite X on a pixel strobe
// SHIFT   | emitting one nibble per pixel strobe
module sprite_fetch_ctrl
  import xosera_pkg::*;
#(
  parameter int         COORD_W    = 11,
  parameter logic [3:0] TRANSP_IDX = 4'd0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               line_start_i,
  input  logic [COORD_W-1:0] h_count_i,
  input  logic [COORD_W-1:0] v_count_i,
  input  logic               pix_en_i,
  input  logic               sprite_en_i,
  input  logic [COORD_W-1:0] sprite_x_i,
  input  logic [COORD_W-1:0] sprite_y_i,
`ifdef SPRITE_HFLIP_EN
  input  logic               hflip_i,
`endif
  sprite_fetch_ctrl_if.master bus
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_FETCH   = FETCH;
  localparam logic [2:0] ST_CAPTURE = CAPTURE;
  localparam logic [2:0] ST_READY   = READY;
  localparam logic [2:0] ST_SHIFT   = SHIFT;

  logic [2:0]         state;
  logic [2:0]         word;
  logic [4:0]         row_q;
  logic [COORD_W-1:0] x_q;
  logic [5:0]         pix_cnt;
  logic               wr_en_q;
  logic [2:0]         wr_idx_q;
  logic [3:0]         pixel_q;
  logic               pixel_valid_q;

  logic [COORD_W-1:0] row_full;
  logic               hit;
  logic [3:0]         buf_nib;
  logic               opaque;

  // modulo subtract: lines above the sprite wrap to large values and miss
  assign row_full = v_count_i - sprite_y_i;
  assign hit      = sprite_en_i && (row_full < COORD_W'(SPRITE_ROWS));
  assign opaque   = (buf_nib != TRANSP_IDX);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      word          <= '0;
      row_q         <= '0;
      x_q           <= '0;
      pix_cnt       <= '0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      // read data trails the address by one clock
      wr_en_q  <= (state == ST_FETCH);
      wr_idx_q <= word;

      if (line_start_i) begin
        x_q           <= sprite_x_i;
        row_q         <= row_full[4:0];
        word          <= '0;
        pix_cnt       <= '0;
        pixel_q       <= '0;
        pixel_valid_q <= 1'b0;
        state         <= hit ? ST_FETCH : ST_IDLE;
      end else begin
        case (state)
          ST_FETCH: begin
            word <= word + 3'd1;
            if (word == 3'(SPRITE_WPR - 1)) state <= ST_CAPTURE;
          end
          ST_CAPTURE: state <= ST_READY;
          ST_READY: begin
            if ((h_count_i == x_q) && pix_en_i) begin
              pixel_q       <= buf_nib;
              pixel_valid_q <= opaque;
              pix_cnt       <= pix_cnt + 6'd1;
              state         <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (pix_en_i) begin
              if (pix_cnt == 6'(SPRITE_PIX)) begin
                pixel_q       <= '0;
                pixel_valid_q <= 1'b0;
                pix_cnt       <= '0;
                state         <= ST_IDLE;
              end else begin
                pixel_q       <= buf_nib;
                pixel_valid_q <= opaque;
                pix_cnt       <= pix_cnt + 6'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic hflip_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)           hflip_q <= 1'b0;
    else if (line_start_i) hflip_q <= hflip_i;
  end
`endif

  sprite_linebuf u_linebuf (
    .clk     (clk),
    .rst     (reset_i),
    .wr_en   (wr_en_q),
    .wr_idx  (wr_idx_q),
    .wr_data (bus.spr_rd_data_i),
    .rd_idx  (pix_cnt[4:0]),
`ifdef SPRITE_HFLIP_EN
    .hflip   (hflip_q),
`endif
    .rd_nib  (buf_nib)
  );

  assign bus.spr_rd_en_o   = (state == ST_FETCH);
  assign bus.spr_rd_addr_o = (state == ST_FETCH) ? {row_q, word} : 8'h00;
  assign bus.pixel_o       = pixel_q;
  assign bus.pixel_valid_o = pixel_valid_q;
  assign bus.busy_o        = (state == ST_FETCH) || (state == ST_CAPTURE) ||
                             (state == ST_SHIFT);

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Scoreboard bench for sprite_fetch_ctrl: expected reads/pixels are queued with
// their cycle number and checked by a negedge monitor.
module tb_sprite_fetch_ctrl;

  typedef struct { int cyc; logic [7:0] addr; } rd_t;
  typedef struct { int cyc; logic [3:0] pix; logic vld; } px_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        line_start = 1'b0;
  logic        pix_en = 1'b0;
  logic        sprite_en = 1'b0;
  logic [10:0] h_count = '0;
  logic [10:0] v_count = '0;
  logic [10:0] sx = '0;
  logic [10:0] sy = '0;
  logic        tb_flip = 1'b0;
`ifdef SPRITE_HFLIP_EN
  logic        hflip = 1'b0;
`endif

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  rd_t exp_rd[$];
  px_t exp_px[$];

  sprite_fetch_ctrl_if bus ();

  sprite_fetch_ctrl #(.COORD_W(11), .TRANSP_IDX(4'd0)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .line_start_i (line_start),
    .h_count_i    (h_count),
    .v_count_i    (v_count),
    .pix_en_i     (pix_en),
    .sprite_en_i  (sprite_en),
    .sprite_x_i   (sx),
    .sprite_y_i   (sy),
`ifdef SPRITE_HFLIP_EN
    .hflip_i      (hflip),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: each word holds its own address
  always @(posedge clk)
    if (bus.spr_rd_en_o) bus.spr_rd_data_i <= {8'h00, bus.spr_rd_addr_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_t r;
    px_t p;
    while (exp_rd.size() != 0 && exp_rd[0].cyc < cyc) begin
      r = exp_rd.pop_front();
      chk("rd_missed_cycle", 32'(cyc), 32'(r.cyc));
    end
    if (exp_rd.size() != 0 && exp_rd[0].cyc == cyc) begin
      r = exp_rd.pop_front();
      chk("rd_en", 32'(bus.spr_rd_en_o), 32'd1);
      chk("rd_addr", 32'(bus.spr_rd_addr_o), 32'(r.addr));
    end else begin
      chk("rd_idle", 32'(bus.spr_rd_en_o), 32'd0);
    end
    while (exp_px.size() != 0 && exp_px[0].cyc < cyc) begin
      p = exp_px.pop_front();
      chk("px_missed_cycle", 32'(cyc), 32'(p.cyc));
    end
    if (exp_px.size() != 0 && exp_px[0].cyc == cyc) begin
      p = exp_px.pop_front();
      chk("pixel", 32'(bus.pixel_o), 32'(p.pix));
      chk("pixel_valid", 32'(bus.pixel_valid_o), 32'(p.vld));
    end else begin
      chk("pixel_idle", {27'd0, bus.pixel_valid_o, bus.pixel_o}, 32'd0);
    end
  end

  function automatic logic [3:0] exp_nib(input logic [4:0] row, input int i, input logic fl);
    int          p;
    logic [2:0]  wi;
    logic [15:0] w;
    p  = fl ? 31 - i : i;
    wi = p[4:2];
    w  = {8'h00, row, wi};
    case (p % 4)
      0:       return w[15:12];
      1:       return w[11:8];
      2:       return w[7:4];
      default: return w[3:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input logic [10:0] v, input logic [10:0] y, input logic [10:0] x,
                         input logic en, output int s, output logic [4:0] row);
    logic [10:0] r;
    line_start = 1'b1;
    v_count    = v;
    sy         = y;
    sx         = x;
    sprite_en  = en;
`ifdef SPRITE_HFLIP_EN
    hflip      = tb_flip;
`endif
    r   = v - y;
    row = r[4:0];
    s   = cyc + 1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic push_reads(input logic [4:0] row, input int s, input int n);
    for (int w = 0; w < n; w++) begin
      logic [2:0] wi;
      wi = 3'(w);
      exp_rd.push_back('{cyc: s + w, addr: {row, wi}});
    end
  endtask

  task automatic push_pix(input logic [4:0] row, input int m, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] nb;
      nb = exp_nib(row, i, tb_flip);
      for (int k = 0; k < per; k++)
        exp_px.push_back('{cyc: m + i * per + k, pix: nb, vld: (nb != 4'd0)});
    end
  endtask

  task automatic shift_line(input logic [10:0] x, input int s, input logic [4:0] row, input int per);
    int m;
    pix_en  = 1'b1;
    h_count = x + 11'd1;
    while (cyc < s + 12) begin
      tick();
      if (cyc == s + 8) chk("busy_capture", 32'(bus.busy_o), 32'd1);
      if (cyc == s + 9) chk("busy_ready", 32'(bus.busy_o), 32'd0);
    end
    h_count = x;
    pix_en  = 1'b0;
    tick();
    pix_en = 1'b1;
    m = cyc + 1;
    push_pix(row, m, per, 32);
    for (int j = 0; j < 32 * per + 2; j++) begin
      tick();
      h_count = h_count + 11'd1;
      pix_en  = ((j + 1) % per == 0);
    end
    chk("busy_after_shift", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic idle_run(input int n);
    for (int j = 0; j < n; j++) begin
      h_count = 11'(j);
      pix_en  = 1'b1;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, s2, m;
    logic [4:0]  row, row2;

    #1;
    chk("rst_rd_en", 32'(bus.spr_rd_en_o), 32'd0);
    chk("rst_rd_addr", 32'(bus.spr_rd_addr_o), 32'd0);
    chk("rst_pixel", 32'(bus.pixel_o), 32'd0);
    chk("rst_valid", 32'(bus.pixel_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // basic hit: row 5, reads 0x28..0x2F, pixels from h_count 50
    do_line(11'd105, 11'd100, 11'd50, 1'b1, s, row);
    push_reads(row, s, 8);
    chk("busy_fetch", 32'(bus.busy_o), 32'd1);
    shift_line(11'd50, s, row, 1);

    // misses: above (wrap), just below, wrapped Y, sprite disabled
    do_line(11'd99, 11'd100, 11'd50, 1'b1, s, row);
    idle_run(60);
    do_line(11'd132, 11'd100, 11'd50, 1'b1, s, row);
    idle_run(60);
    do_line(11'd3, 11'd2000, 11'd50, 1'b1, s, row);
    idle_run(30);
    do_line(11'd105, 11'd100, 11'd50, 1'b0, s, row);
    idle_run(30);
    chk("busy_after_miss", 32'(bus.busy_o), 32'd0);

    // hit at the last row, X never reached: nothing drawn, next line aborts READY
    do_line(11'd131, 11'd100, 11'd500, 1'b1, s, row);
    push_reads(row, s, 8);
    idle_run(40);
    do_line(11'd99, 11'd100, 11'd500, 1'b1, s, row);
    idle_run(20);

    // restart during FETCH after 4 reads: buffer must reflect new row only
    do_line(11'd105, 11'd100, 11'd50, 1'b1, s, row);
    push_reads(row, s, 4);
    while (cyc < s + 3) tick();
    do_line(11'd110, 11'd100, 11'd50, 1'b1, s2, row2);
    push_reads(row2, s2, 8);
    shift_line(11'd50, s2, row2, 1);

    // strobe every second clock, row 20 (words 0x00A0..0x00A7)
    do_line(11'd120, 11'd100, 11'd60, 1'b1, s, row);
    push_reads(row, s, 8);
    shift_line(11'd60, s, row, 2);
    idle_run(10);

    // async reset in the middle of SHIFT
    do_line(11'd120, 11'd100, 11'd60, 1'b1, s, row);
    push_reads(row, s, 8);
    pix_en  = 1'b1;
    h_count = 11'd0;
    while (cyc < s + 12) tick();
    h_count = 11'd60;
    m = cyc + 1;
    push_pix(row, m, 1, 2);
    tick();
    tick();
    tick();
    chk("pre_reset_pixel", 32'(bus.pixel_o), 32'hA);
    chk("pre_reset_valid", 32'(bus.pixel_valid_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.pixel_valid_o), 32'd0);
    chk("async_rst_pixel", 32'(bus.pixel_o), 32'd0);
    chk("async_rst_rd_en", 32'(bus.spr_rd_en_o), 32'd0);
    chk("async_rst_busy", 32'(bus.busy_o), 32'd0);
    tick();
    reset_i = 1'b0;
    pix_en  = 1'b0;
    tick();
    tick();

`ifdef SPRITE_HFLIP_EN
    // mirrored: word7[3:0] first
    tb_flip = 1'b1;
    do_line(11'd105, 11'd100, 11'd50, 1'b1, s, row);
    push_reads(row, s, 8);
    shift_line(11'd50, s, row, 1);
    tb_flip = 1'b0;
`endif

    idle_run(5);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("px_queue_drained", 32'(exp_px.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
